// File: rtl/password_lock_ctrl.sv
// Password lock controller: digit-by-digit code entry with retry counting,
// timed error and lockout displays, and password change from the open state.
module password_lock_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int FAIL_CYCLES = 50_000_000,
  parameter int LOCK_CYCLES = 500_000_000,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = 16'h1234
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter,
  input  logic                clear,
  input  logic                change,
  input  logic [DIGIT_W-1:0]  switch,
  output logic [7*DIGITS-1:0] ssd,
  output logic [7:0]          led
);

  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int MAX_CYC = (FAIL_CYCLES > LOCK_CYCLES) ? FAIL_CYCLES : LOCK_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int POS_W   = $clog2(DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [TIMER_W-1:0] FAIL_LAST = TIMER_W'(FAIL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [POS_W-1:0]   POS_FULL  = POS_W'(DIGITS);
  localparam logic [TRY_W-1:0]   TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [6:0]         SEG_DASH  = 7'b0111111;
  localparam logic [6:0]         SEG_E     = 7'b0000110;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_FAIL    = 3'd2,
    S_LOCKOUT = 3'd3,
    S_OPEN    = 3'd4,
    S_SET     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CODE_W-1:0]   r_pw;
  logic [CODE_W-1:0]   r_buf;
  logic [CODE_W-1:0]   w_buf_wr;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    w_pos_inc;
  logic [TRY_W-1:0]    r_tries;
  logic [TIMER_W-1:0]  r_timer;
  logic [7*DIGITS-1:0] r_ssd_q;
  logic                r_enter_q;
  logic                r_clear_q;
  logic                r_change_q;
  logic                r_armed;

  logic w_enter_e;
  logic w_clear_e;
  logic w_change_e;
  logic w_clr;
  logic w_chg;
  logic w_ent;
  logic w_full;
  logic w_match;
  logic w_last_try;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // r_armed masks the first cycle after reset so a button held through reset
  // release does not register as a press.
  assign w_enter_e  = enter  & ~r_enter_q  & r_armed;
  assign w_clear_e  = clear  & ~r_clear_q  & r_armed;
  assign w_change_e = change & ~r_change_q & r_armed;

  assign w_clr = w_clear_e;
  assign w_chg = w_change_e & ~w_clear_e;
  assign w_ent = w_enter_e & ~w_clear_e & ~w_change_e;

  assign w_pos_inc  = r_pos + 1'b1;
  assign w_full     = (w_pos_inc == POS_FULL);
  assign w_match    = (r_buf == r_pw);
  assign w_last_try = ((r_tries + 1'b1) == TRY_LIMIT);

  always_comb begin
    w_buf_wr = r_buf;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_pos == POS_W'(i)) begin
        w_buf_wr[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = switch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_ENTRY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ENTRY: begin
        if (w_ent && w_full) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_match)         w_next = S_OPEN;
        else if (w_last_try) w_next = S_LOCKOUT;
        else                 w_next = S_FAIL;
      end
      S_FAIL: begin
        if (r_timer == FAIL_LAST) w_next = S_ENTRY;
      end
      S_LOCKOUT: begin
        if (r_timer == LOCK_LAST) w_next = S_ENTRY;
      end
      S_OPEN: begin
        if (w_clr)      w_next = S_ENTRY;
        else if (w_chg) w_next = S_SET;
      end
      S_SET: begin
        if (w_clr)               w_next = S_OPEN;
        else if (w_ent && w_full) w_next = S_ENTRY;
      end
      default: w_next = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pw       <= RESET_CODE;
      r_buf      <= '0;
      r_pos      <= '0;
      r_tries    <= '0;
      r_timer    <= '0;
      r_ssd_q    <= {DIGITS{SEG_DASH}};
      r_enter_q  <= 1'b0;
      r_clear_q  <= 1'b0;
      r_change_q <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_enter_q  <= enter;
      r_clear_q  <= clear;
      r_change_q <= change;
      r_armed    <= 1'b1;
      r_ssd_q    <= ssd;

      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_state == S_FAIL || r_state == S_LOCKOUT) begin
        r_timer <= r_timer + 1'b1;
      end

      case (r_state)
        S_ENTRY, S_SET: begin
          if (w_clr) begin
            r_buf <= '0;
            r_pos <= '0;
          end else if (w_ent) begin
            // A completed SET commits straight to the password; a completed
            // ENTRY keeps the full buffer for the compare in CHECK.
            if (w_full && r_state == S_SET) begin
              r_pw  <= w_buf_wr;
              r_buf <= '0;
              r_pos <= '0;
            end else begin
              r_buf <= w_buf_wr;
              r_pos <= w_pos_inc;
            end
          end
        end
        S_CHECK: begin
          r_pos <= '0;
          if (w_match) begin
            r_tries <= '0;
          end else begin
            r_buf <= '0;
            if (r_tries != TRY_LIMIT) r_tries <= r_tries + 1'b1;
          end
        end
        S_FAIL: begin
          if (r_timer == FAIL_LAST) r_buf <= '0;
        end
        S_LOCKOUT: begin
          if (r_timer == LOCK_LAST) begin
            r_buf   <= '0;
            r_tries <= '0;
          end
        end
        S_OPEN: begin
          if (w_clr || w_chg) begin
            r_buf <= '0;
            r_pos <= '0;
          end
        end
        default: begin
          r_buf <= '0;
          r_pos <= '0;
        end
      endcase
    end
  end

  always_comb begin
    logic [3:0] v;
    ssd = {DIGITS{SEG_DASH}};
    v   = '0;
    if (r_state == S_CHECK) begin
      ssd = r_ssd_q;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        v = 4'(r_buf[(DIGITS-1-i)*DIGIT_W +: DIGIT_W]);
        case (r_state)
          S_ENTRY, S_SET: begin
            if (POS_W'(i) < r_pos) ssd[(DIGITS-1-i)*7 +: 7] = seg7(v);
          end
          S_OPEN:  ssd[(DIGITS-1-i)*7 +: 7] = seg7(v);
          S_FAIL:  ssd[(DIGITS-1-i)*7 +: 7] = SEG_E;
          default: ssd[(DIGITS-1-i)*7 +: 7] = SEG_DASH;
        endcase
      end
    end
    led = {4'(r_pos), (r_state == S_SET), (r_state == S_LOCKOUT),
           (r_state == S_FAIL), (r_state == S_OPEN)};
  end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Bench for password_lock_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model through an expected queue.
module tb_password_lock_ctrl;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 4;
  localparam int MAX_TRIES   = 3;
  localparam int FAIL_CYCLES = 4;
  localparam int LOCK_CYCLES = 8;
  localparam logic [15:0] RESET_CODE = 16'h1234;
  localparam int OW = 7*DIGITS + 8;

  localparam logic [6:0]  SEG_DASH = 7'h3F;
  localparam logic [6:0]  SEG_E    = 7'h06;
  localparam logic [27:0] DASH4    = {4{SEG_DASH}};
  localparam logic [27:0] E4       = {4{SEG_E}};
  localparam logic [27:0] SHOW_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SHOW_9876 = {7'h10, 7'h00, 7'h78, 7'h02};
  localparam logic [27:0] SHOW_0000 = {4{7'h40}};

  localparam int M_ENTRY = 0, M_CHECK = 1, M_FAIL = 2, M_LOCK = 3, M_OPEN = 4, M_SET = 5;

  // clock / reset / DUT
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enter = 1'b0;
  logic clear = 1'b0;
  logic change = 1'b0;
  logic [DIGIT_W-1:0] switch = '0;
  logic [7*DIGITS-1:0] ssd;
  logic [7:0] led;

  password_lock_ctrl #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
    .FAIL_CYCLES(FAIL_CYCLES), .LOCK_CYCLES(LOCK_CYCLES), .RESET_CODE(RESET_CODE)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .clear(clear), .change(change),
    .switch(switch), .ssd(ssd), .led(led)
  );

  always #5 clk = ~clk;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  string phase = "reset";
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mon_exp;

  // behavioural model
  int m_mode, m_pos, m_tries, m_dwell;
  int m_pw[DIGITS];
  int m_buf[DIGITS];
  bit m_prev_ent, m_prev_clr, m_prev_chg;
  logic [27:0] m_last_ssd;
  logic [6:0] hex_tbl[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_val(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got ssd=%h led=%h, expected ssd=%h led=%h",
               name, $time, act[OW-1:8], act[7:0], exp[OW-1:8], exp[7:0]);
    end
  endtask

  task automatic expect_now(input string name, input logic [7:0] exp_led, input logic [27:0] exp_ssd);
    check_val(name, {ssd, led}, {exp_ssd, exp_led});
  endtask

  task automatic clear_buf();
    for (int i = 0; i < DIGITS; i++) m_buf[i] = 0;
  endtask

  task automatic model_reset();
    logic [15:0] rc;
    rc = RESET_CODE;
    for (int i = 0; i < DIGITS; i++) m_pw[i] = int'(rc[(DIGITS-1-i)*4 +: 4]);
    clear_buf();
    m_mode = M_ENTRY;
    m_pos = 0;
    m_tries = 0;
    m_dwell = 0;
    // A button still down when reset lifts must not count as a press.
    m_prev_ent = 1'b1;
    m_prev_clr = 1'b1;
    m_prev_chg = 1'b1;
    m_last_ssd = DASH4;
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [27:0] s;
    logic [7:0] l;
    logic [6:0] d;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      case (m_mode)
        M_ENTRY, M_SET: d = (i < m_pos) ? hex_tbl[m_buf[i]] : SEG_DASH;
        M_OPEN:  d = hex_tbl[m_buf[i]];
        M_FAIL:  d = SEG_E;
        M_CHECK: d = m_last_ssd[(DIGITS-1-i)*7 +: 7];
        default: d = SEG_DASH;
      endcase
      s[(DIGITS-1-i)*7 +: 7] = d;
    end
    l = {4'(m_pos), m_mode == M_SET, m_mode == M_LOCK, m_mode == M_FAIL, m_mode == M_OPEN};
    return {s, l};
  endfunction

  task automatic model_step(input bit e, input bit c, input bit ch, input int sw, input bit rst);
    bit ce, he, ee, same;
    int nmode;
    logic [OW-1:0] o;
    if (!rst) begin
      model_reset();
    end else begin
      ce = c && !m_prev_clr;
      he = ch && !m_prev_chg && !ce;
      ee = e && !m_prev_ent && !ce && !he;
      m_prev_ent = e;
      m_prev_clr = c;
      m_prev_chg = ch;
      nmode = m_mode;
      case (m_mode)
        M_ENTRY, M_SET: begin
          if (ce) begin
            clear_buf();
            m_pos = 0;
            if (m_mode == M_SET) nmode = M_OPEN;
          end else if (ee) begin
            m_buf[m_pos] = sw;
            m_pos++;
            if (m_pos == DIGITS) begin
              if (m_mode == M_ENTRY) nmode = M_CHECK;
              else begin
                m_pw = m_buf;
                clear_buf();
                m_pos = 0;
                nmode = M_ENTRY;
              end
            end
          end
        end
        M_CHECK: begin
          same = 1'b1;
          for (int i = 0; i < DIGITS; i++) if (m_buf[i] != m_pw[i]) same = 1'b0;
          m_pos = 0;
          if (same) begin
            nmode = M_OPEN;
            m_tries = 0;
          end else begin
            m_tries++;
            clear_buf();
            nmode = (m_tries == MAX_TRIES) ? M_LOCK : M_FAIL;
          end
        end
        M_FAIL: if (m_dwell == FAIL_CYCLES - 1) begin
          nmode = M_ENTRY;
          clear_buf();
        end
        M_LOCK: if (m_dwell == LOCK_CYCLES - 1) begin
          nmode = M_ENTRY;
          clear_buf();
          m_tries = 0;
        end
        M_OPEN: if (ce || he) begin
          clear_buf();
          m_pos = 0;
          nmode = ce ? M_ENTRY : M_SET;
        end
        default: nmode = M_ENTRY;
      endcase
      m_dwell = (nmode == m_mode) ? m_dwell + 1 : 0;
      m_mode = nmode;
    end
    o = model_out();
    m_last_ssd = o[OW-1:8];
    exp_q.push_back(o);
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic cyc(input bit e, input bit c, input bit ch, input int sw, input bit rst = 1'b1);
    @(negedge clk);
    enter = e;
    clear = c;
    change = ch;
    switch = DIGIT_W'(sw);
    reset = rst;
    model_step(e, c, ch, sw, rst);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  task automatic press_digit(input int d);
    cyc(1, 0, 0, d);
    cyc(0, 0, 0, d);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < DIGITS; i++) press_digit(int'(code[(DIGITS-1-i)*4 +: 4]));
  endtask

  // monitor: one expected word per clock, sampled after the rising edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check_val(phase, {ssd, led}, mon_exp);
    end
  end

  initial begin
    int sw;
    phase = "reset";
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    expect_now("reset_state", 8'h00, DASH4);

    phase = "open_1234";
    press_digit(1);
    press_digit(2);
    expect_now("pos_two", 8'h20, {7'h79, 7'h24, SEG_DASH, SEG_DASH});
    press_digit(3);
    press_digit(4);
    idle(1);
    expect_now("open_1234", 8'h01, SHOW_1234);
    cyc(0, 1, 0, 0);
    idle(1);
    expect_now("relock", 8'h00, DASH4);

    phase = "wrong_code";
    enter_code(16'h1235);
    idle(1);
    expect_now("wrong_shows_e", 8'h02, E4);
    press_digit(7);
    idle(FAIL_CYCLES + 1);
    expect_now("after_wrong", 8'h00, DASH4);

    phase = "lockout";
    enter_code(16'h1234);
    cyc(0, 1, 0, 0);
    idle(1);
    enter_code(16'h1111);
    idle(6);
    enter_code(16'h2222);
    idle(6);
    enter_code(16'h3333);
    idle(1);
    expect_now("lockout_state", 8'h04, DASH4);
    idle(LOCK_CYCLES + 1);
    enter_code(16'h1234);
    idle(1);
    expect_now("open_after_lock", 8'h01, SHOW_1234);
    cyc(0, 1, 0, 0);
    idle(1);

    phase = "clear_entry";
    press_digit(1);
    press_digit(2);
    cyc(0, 1, 0, 0);
    idle(1);
    expect_now("clear_mid_entry", 8'h00, DASH4);
    press_digit(3);
    cyc(1, 1, 0, 5);
    idle(1);
    expect_now("clear_beats_enter", 8'h00, DASH4);

    phase = "change_pw";
    enter_code(16'h1234);
    idle(1);
    cyc(0, 0, 1, 0);
    idle(1);
    expect_now("set_mode", 8'h08, DASH4);
    enter_code(16'h9876);
    idle(1);
    expect_now("set_done", 8'h00, DASH4);
    enter_code(16'h1234);
    idle(1);
    expect_now("old_pw_rejected", 8'h02, E4);
    idle(FAIL_CYCLES + 1);
    enter_code(16'h9876);
    idle(1);
    expect_now("new_pw_opens", 8'h01, SHOW_9876);
    cyc(0, 0, 1, 0);
    idle(1);
    press_digit(5);
    press_digit(5);
    cyc(0, 1, 0, 0);
    idle(1);
    expect_now("set_abort", 8'h01, SHOW_0000);
    cyc(0, 1, 0, 0);
    idle(1);

    phase = "hold_enter";
    repeat (20) cyc(1, 0, 0, 3);
    cyc(0, 0, 0, 0);
    expect_now("hold_one_digit", 8'h10, {7'h30, SEG_DASH, SEG_DASH, SEG_DASH});
    cyc(0, 1, 0, 0);
    idle(1);

    phase = "reset_in_set";
    enter_code(16'h9876);
    idle(1);
    cyc(0, 0, 1, 0);
    idle(1);
    press_digit(1);
    cyc(1, 0, 0, 4, 0);
    cyc(1, 0, 0, 4, 0);
    repeat (3) cyc(1, 0, 0, 4);
    cyc(0, 0, 0, 0);
    expect_now("reset_mid_set", 8'h00, DASH4);
    enter_code(16'h1234);
    idle(1);
    expect_now("reset_code_back", 8'h01, SHOW_1234);
    cyc(0, 1, 0, 0);
    idle(1);

    phase = "random";
    for (int k = 0; k < 1200; k++) begin
      if (m_pos < DIGITS && $urandom_range(0, 9) < 7) sw = m_pw[m_pos];
      else sw = int'($urandom_range(0, 15));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 19) == 0, sw, $urandom_range(0, 399) != 0);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
